pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the processor front end, replacing the fixed 8-bit PC register. Holds the fetch PC and selects each cycle's next value from a fixed-priority set of sources: reset vector, debug load, trap vector, stall hold, return-address pop, branch/jump redirect, and sequential increment. An optional return-address stack (RAS) pushes the link address on calls and supplies the target on returns. Sits between the branch/control logic and the instruction-memory address port.

## Interface
- PC_W, 8, PC and address width in bits
- STEP, 1, sequential increment added to PC each advancing cycle
- RESET_VEC, 0, PC value after reset
- TRAP_VEC, 'hF0 (truncated to PC_W), PC value loaded on trap
- RAS_DEPTH, 4, RAS entries; must be a power of two, at least 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- load  in  1  debug load strobe, active-high
- load_val  in  PC_W  value written to PC on load
- trap  in  1  exception redirect to TRAP_VEC
- stall  in  1  hold PC; blocks ret, redirect, call, increment
- redirect  in  1  taken branch/jump
- redirect_target  in  PC_W  branch/jump target
- call  in  1  qualifies redirect as call; pushes link address
- ret  in  1  return; PC takes RAS top and RAS pops
- pc  out  PC_W  registered current PC
- pc_next  out  PC_W  combinational value pc takes at the next edge
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  sticky; set when a push overwrites an entry

## Operation
- Next-PC priority, highest first:
  - reset → RESET_VEC
  - load → load_val
  - trap → TRAP_VEC
  - stall → pc (hold)
  - ret → RAS top
  - redirect → redirect_target
  - otherwise → pc + STEP
- All PC arithmetic is modulo 2^PC_W. pc + STEP wraps silently; the wrap is not an error.
- Link address = pc + STEP (mod 2^PC_W), taken from the cycle in which the call is accepted.
- Push happens only when redirect & call is the winning source. call without redirect is ignored.
- Pop happens only when ret is the winning source.
- ret and redirect/call in the same cycle: ret wins. No push occurs and redirect is dropped.
- load and trap do not modify the RAS.
- RAS is a circular buffer with write pointer sp and occupancy count cnt.
  - Push onto a full RAS: overwrite the oldest entry, sp wraps, cnt stays at RAS_DEPTH, ras_ovf sets.
  - ret with an empty RAS: PC takes pc + STEP (treated as increment). cnt stays at 0. No other side effect.
- ras_ovf clears only on reset.
- Reset values: pc = RESET_VEC, cnt = 0, sp = 0, ras_empty = 1, ras_full = 0, ras_ovf = 0. RAS entry contents are don't-care.

## Timing
- Single clock domain. Every state change occurs on the rising edge of clk.
- Latency from any control input to pc is one cycle. pc_next reflects the current inputs in the same cycle.
- reset asserted mid-operation overrides every other input in that cycle, including an in-flight push or pop.
- ras_empty and ras_full are registered and decoded from cnt; they update in the same edge as the push or pop.
- A stall cycle consumes no input. The control unit must hold redirect, call and ret asserted until the cycle stall drops.

## Configuration
- RAS_EN defined: RAS logic, call/ret behaviour and the ras_* outputs are as specified above.
- RAS_EN undefined:
  - No RAS storage is built.
  - ret is ignored; priority falls through to redirect/increment.
  - call is ignored; redirect still applies.
  - ras_empty = 1, ras_full = 0, ras_ovf = 0 constant.

## Structure
- pc_unit_pkg holds:
  - the next-source enum: SRC_RESET, SRC_LOAD, SRC_TRAP, SRC_HOLD, SRC_RET, SRC_REDIR, SRC_INC
  - the default vector constants for RESET_VEC and TRAP_VEC
- One sub-module, pc_ras, contains the stack storage, sp/cnt logic and the flags. It is instantiated only under RAS_EN.
- The top level contains the priority selector and the PC register.

## Test plan
- Reset, then 3 free-running cycles with PC_W=8, STEP=1 → pc = 0, 1, 2, 3. Set pc = 'hFF via load, next cycle → pc = 'h00 (wrap).
- At pc = 'h10, redirect=1, call=1, target='h40 → pc = 'h40, RAS top = 'h11. After 2 increments, ret=1 → pc = 'h11, ras_empty = 1.
- stall=1 with redirect=1 (target 'h80) held for 3 cycles → pc unchanged. Release stall → pc = 'h80 one cycle later.
- trap=1, stall=1, ret=1 all in one cycle → pc = 'hF0, cnt unchanged. Same cycle plus load=1, load_val='h33 → pc = 'h33.
- Five calls with RAS_DEPTH=4 → ras_full = 1 after the 4th, ras_ovf = 1 after the 5th. Four rets return the last four link addresses in LIFO order. A 5th ret → pc + 1.
- Assert reset mid-call-sequence → pc = 0, ras_empty = 1, ras_ovf = 0 on the next edge. Rebuild with RAS_EN undefined: ret=1 → pc increments.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared types and default vectors for the program-counter unit.
// Optional return-address stack is enabled by defining RAS_EN.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_LOAD,
    SRC_TRAP,
    SRC_HOLD,
    SRC_RET,
    SRC_REDIR,
    SRC_INC
  } src_e;

  localparam int DEF_RESET_VEC = 'h00;
  localparam int DEF_TRAP_VEC  = 'hF0;

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer with write pointer sp and
// occupancy count; a push onto a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_val,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            ovf
);

  localparam int SW = $clog2(DEPTH);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [SW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            empty_q, full_q;
  logic            ovf_q, ovf_d;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      sp_d = sp_q + SW'(1);
      if (cnt_q == FULL_CNT) ovf_d = 1'b1;
      else                   cnt_d = cnt_q + CW'(1);
    end else if (pop && cnt_q != '0) begin
      sp_d  = sp_q - SW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
      ovf_q   <= ovf_d;
    end
  end

  // Entry contents need no reset; only sp/cnt define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[sp_q] <= push_val;
  end

  assign top   = mem_q[sp_q - SW'(1)];
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with fixed-priority next-PC selection.
// Define RAS_EN to build the return-address stack (call/ret support).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter int              STEP      = 1,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            trap,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty_w;
  logic            ret_en, call_en;
  src_e            src;

  assign pc_inc = pc_q + PC_W'(STEP);

`ifdef RAS_EN
  logic ras_push, ras_pop;

  assign ret_en   = ret;
  assign call_en  = call;
  assign ras_push = (src == SRC_REDIR) && call_en;
  assign ras_pop  = (src == SRC_RET) && !ras_empty_w;

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_val (pc_inc),
    .top      (ras_top),
    .empty    (ras_empty_w),
    .full     (ras_full),
    .ovf      (ras_ovf)
  );
`else
  logic unused_ras;

  assign ret_en      = 1'b0;
  assign call_en     = 1'b0;
  assign ras_top     = '0;
  assign ras_empty_w = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_ovf     = 1'b0;
  assign unused_ras  = ^{call, ret, call_en};
`endif

  always_comb begin
    if (reset)         src = SRC_RESET;
    else if (load)     src = SRC_LOAD;
    else if (trap)     src = SRC_TRAP;
    else if (stall)    src = SRC_HOLD;
    else if (ret_en)   src = SRC_RET;
    else if (redirect) src = SRC_REDIR;
    else               src = SRC_INC;
  end

  always_comb begin
    pc_d = pc_inc;
    unique case (src)
      SRC_RESET: pc_d = RESET_VEC;
      SRC_LOAD:  pc_d = load_val;
      SRC_TRAP:  pc_d = TRAP_VEC;
      SRC_HOLD:  pc_d = pc_q;
      // Return with nothing on the stack degrades to an increment.
      SRC_RET:   pc_d = ras_empty_w ? pc_inc : ras_top;
      SRC_REDIR: pc_d = redirect_target;
      SRC_INC:   pc_d = pc_inc;
      default:   pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  assign pc        = pc_q;
  assign pc_next   = pc_d;
  assign ras_empty = ras_empty_w;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (both RAS_EN builds)
// plus a standalone check of the pc_ras stack.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       reset, load, trap, stall, redirect, call, ret;
  logic [7:0] load_val, redirect_target;
  logic [7:0] pc, pc_next;
  logic       ras_empty, ras_full, ras_ovf;

  logic       r_reset, r_push, r_pop;
  logic [7:0] r_val, r_top;
  logic       r_empty, r_full, r_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk             (clk),
    .reset           (reset),
    .load            (load),
    .load_val        (load_val),
    .trap            (trap),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .call            (call),
    .ret             (ret),
    .pc              (pc),
    .pc_next         (pc_next),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ras_ovf         (ras_ovf)
  );

  pc_ras #(.PC_W(8), .DEPTH(4)) u_ras (
    .clk      (clk),
    .reset    (r_reset),
    .push     (r_push),
    .pop      (r_pop),
    .push_val (r_val),
    .top      (r_top),
    .empty    (r_empty),
    .full     (r_full),
    .ovf      (r_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load = 0; trap = 0; stall = 0;
    redirect = 0; call = 0; ret = 0;
  endtask

  logic [7:0] held;

  initial begin
    idle();
    load_val = 0; redirect_target = 0;
    r_reset = 1; r_push = 0; r_pop = 0; r_val = 0;
    reset = 1;
    step();
    chk("rst_pc", pc, 8'h00);
    chk("rst_empty", ras_empty, 1'b1);
    chk("rst_full", ras_full, 1'b0);
    chk("rst_ovf", ras_ovf, 1'b0);
    load = 1; load_val = 8'h77;
    #1 chk("rst_beats_load", pc_next, 8'h00);
    load = 0;
    reset = 0;
    #1 chk("pcnext_inc", pc_next, 8'h01);
    step(); chk("run1", pc, 8'h01);
    step(); chk("run2", pc, 8'h02);
    step(); chk("run3", pc, 8'h03);

    load = 1; load_val = 8'hFF;
    step(); chk("load_ff", pc, 8'hFF);
    load = 0;
    step(); chk("wrap", pc, 8'h00);

    load = 1; load_val = 8'h10;
    step(); load = 0;
    redirect = 1; call = 1; redirect_target = 8'h40;
    #1 chk("call_next", pc_next, 8'h40);
    step(); chk("call_pc", pc, 8'h40);
`ifdef RAS_EN
    chk("call_nonempty", ras_empty, 1'b0);
`endif
    idle();
    step(); step(); chk("inc2", pc, 8'h42);
    ret = 1;
    step();
`ifdef RAS_EN
    chk("ret_pc", pc, 8'h11);
`else
    chk("ret_ignored", pc, 8'h43);
`endif
    chk("ret_empty", ras_empty, 1'b1);
    idle();

    held = pc;
    stall = 1; redirect = 1; redirect_target = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", pc, held);
    end
    stall = 0;
    step(); chk("stall_release", pc, 8'h80);

    call = 1; redirect_target = 8'h50;
    step(); chk("call2", pc, 8'h50);
    idle();
    trap = 1; stall = 1; ret = 1;
    step(); chk("trap_pc", pc, 8'hF0);
`ifdef RAS_EN
    chk("trap_keeps_ras", ras_empty, 1'b0);
`endif
    load = 1; load_val = 8'h33;
    step(); chk("load_beats_trap", pc, 8'h33);
    idle();
    ret = 1;
    step();
`ifdef RAS_EN
    chk("ret_after_trap", pc, 8'h81);
`else
    chk("ret_after_trap", pc, 8'h34);
`endif
    idle();

    load = 1; load_val = 8'h20;
    step(); idle();
    redirect = 1; call = 1;
    for (int i = 0; i < 5; i++) begin
      redirect_target = pc + 8'h10;
      step();
      chk("call_seq", pc, 8'h30 + 8'(i) * 8'h10);
`ifdef RAS_EN
      chk("call_full", ras_full, (i >= 3) ? 1'b1 : 1'b0);
      chk("call_ovf", ras_ovf, (i >= 4) ? 1'b1 : 1'b0);
`else
      chk("call_full", ras_full, 1'b0);
`endif
    end
    idle();
    ret = 1;
    begin
`ifdef RAS_EN
      logic [7:0] exp_ret [5] = '{8'h61, 8'h51, 8'h41, 8'h31, 8'h32};
`else
      logic [7:0] exp_ret [5] = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
`endif
      for (int i = 0; i < 5; i++) begin
        step(); chk("ret_seq", pc, exp_ret[i]);
      end
    end
    chk("ret_seq_empty", ras_empty, 1'b1);
    idle();

    redirect = 1; call = 1; redirect_target = 8'h90;
    step(); chk("pre_rst_call", pc, 8'h90);
    reset = 1;
    step();
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_empty", ras_empty, 1'b1);
    chk("midrst_ovf", ras_ovf, 1'b0);
    chk("midrst_full", ras_full, 1'b0);
    reset = 0; idle();

    step();
    chk("ras_rst_empty", r_empty, 1'b1);
    r_reset = 0;
    r_pop = 1;
    step(); chk("ras_pop_empty", r_empty, 1'b1);
    r_pop = 0; r_push = 1;
    for (int i = 1; i <= 5; i++) begin
      r_val = 8'(i) * 8'h11;
      step();
      chk("ras_top_push", r_top, 8'(i) * 8'h11);
      chk("ras_full_push", r_full, (i >= 4) ? 1'b1 : 1'b0);
      chk("ras_ovf_push", r_ovf, (i >= 5) ? 1'b1 : 1'b0);
    end
    r_push = 0; r_pop = 1;
    for (int i = 4; i >= 2; i--) begin
      step(); chk("ras_top_pop", r_top, 8'(i) * 8'h11);
    end
    step(); chk("ras_last_empty", r_empty, 1'b1);
    chk("ras_ovf_sticky", r_ovf, 1'b1);
    r_pop = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
